// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - Start/Done request/result bundle for alu_seq_unit
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] HiResult;
    logic             ZeroFlag;
    logic             Overflow;
    logic             IllegalOp;

    modport master (
        output Start, SrcA, SrcB, ALUControl,
        input  Busy, Done, ALUResult, HiResult, ZeroFlag, Overflow, IllegalOp
    );

    modport slave (
        input  Start, SrcA, SrcB, ALUControl,
        output Busy, Done, ALUResult, HiResult, ZeroFlag, Overflow, IllegalOp
    );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered ALU with Start/Done handshake; ALU_MULT_EN adds an iterative MULTU
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input logic           CLK,
    input logic           ResetN,
    alu_seq_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] hi_result_q, hi_result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] sum, diff, op_result;
    logic [SHW-1:0]   shamt;
    logic             op_ovf, op_illegal, take_single;

    assign sum   = bus.SrcA + bus.SrcB;
    assign diff  = bus.SrcA - bus.SrcB;
    assign shamt = bus.SrcB[SHW-1:0];

`ifdef ALU_MULT_EN
    localparam logic [3:0] OP_MULTU = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d, step_prod;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [SHW:0]         cnt_q, cnt_d;
    logic [WIDTH:0]       step_hi;

    // prod_q = {partial high word, remaining multiplier bits}; one shift-add per cycle
    assign step_hi     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign step_prod   = {step_hi, prod_q[WIDTH-1:1]};
    assign take_single = (state_q == S_IDLE) && bus.Start && (bus.ALUControl != OP_MULTU);
    assign bus.Busy    = (state_q == S_MUL);
`else
    assign take_single = bus.Start;
    assign bus.Busy    = 1'b0;
`endif

    always_comb begin
        op_result  = '0;
        op_ovf     = 1'b0;
        op_illegal = 1'b0;
        case (bus.ALUControl)
            OP_AND:  op_result = bus.SrcA & bus.SrcB;
            OP_OR:   op_result = bus.SrcA | bus.SrcB;
            OP_ADD: begin
                op_result = sum;
                op_ovf    = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = diff;
                op_ovf    = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) && (diff[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            OP_XOR:  op_result = bus.SrcA ^ bus.SrcB;
            OP_NOR:  op_result = ~(bus.SrcA | bus.SrcB);
            OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
            OP_SLL:  op_result = bus.SrcA << shamt;
            OP_SRL:  op_result = bus.SrcA >> shamt;
            OP_SRA:  op_result = $signed(bus.SrcA) >>> shamt;
`ifdef ALU_MULT_EN
            OP_MULTU: op_result = '0;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        done_d       = 1'b0;
        alu_result_d = alu_result_q;
        hi_result_d  = hi_result_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        illegal_d    = illegal_q;
        if (take_single) begin
            done_d       = 1'b1;
            alu_result_d = op_result;
            hi_result_d  = '0;
            zero_d       = (op_result == '0);
            ovf_d        = op_ovf;
            illegal_d    = op_illegal;
        end
`ifdef ALU_MULT_EN
        state_d = state_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start && (bus.ALUControl == OP_MULTU)) begin
                    state_d = S_MUL;
                    prod_d  = {{WIDTH{1'b0}}, bus.SrcB};
                    mcand_d = bus.SrcA;
                    cnt_d   = (SHW+1)'(WIDTH);
                end
            end
            S_MUL: begin
                prod_d = step_prod;
                cnt_d  = cnt_q - (SHW+1)'(1);
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    alu_result_d = step_prod[WIDTH-1:0];
                    hi_result_d  = step_prod[2*WIDTH-1:WIDTH];
                    zero_d       = (step_prod[WIDTH-1:0] == '0);
                    ovf_d        = 1'b0;
                    illegal_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
`endif
    end

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            done_q       <= 1'b0;
            alu_result_q <= '0;
            hi_result_q  <= '0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef ALU_MULT_EN
            state_q      <= S_IDLE;
            prod_q       <= '0;
            mcand_q      <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            done_q       <= done_d;
            alu_result_q <= alu_result_d;
            hi_result_q  <= hi_result_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            illegal_q    <= illegal_d;
`ifdef ALU_MULT_EN
            state_q      <= state_d;
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.Done      = done_q;
    assign bus.ALUResult = alu_result_q;
    assign bus.HiResult  = hi_result_q;
    assign bus.ZeroFlag  = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.IllegalOp = illegal_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - randomized and directed bench for alu_seq_unit (WIDTH=32)
module tb_alu_seq_unit;
    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(32)) bus ();
    alu_seq_unit #(.WIDTH(32)) dut (.CLK(clk), .ResetN(resetn), .bus(bus));

`ifdef ALU_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    // lat counts edges from the accepting edge to the Done edge inclusive
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [66:0] exp, output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        logic [31:0] r, hi;
        logic ov, il;
        sa = $signed(a);
        sb = $signed(b);
        r = 0; hi = 0; ov = 0; il = 0; lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin s = sa + sb; r = a + b; ov = (s != longint'($signed(r))); end
            4'd3: begin s = sa - sb; r = a - b; ov = (s != longint'($signed(r))); end
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: begin s = sa >>> b[4:0]; r = s[31:0]; end
            4'd11: begin
                if (MULT_EN) begin
                    p = {32'b0, a} * {32'b0, b};
                    r = p[31:0]; hi = p[63:32]; lat = 33;
                end else il = 1;
            end
            default: il = 1;
        endcase
        exp = {r, hi, (r == 0), ov, il};
    endtask

    function automatic logic [66:0] observed();
        return {bus.ALUResult, bus.HiResult, bus.ZeroFlag, bus.Overflow, bus.IllegalOp};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
        @(negedge clk);
        bus.Start = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.SrcA = $urandom; bus.SrcB = $urandom;
        lat = 1; busy_n = 0;
        while (!bus.Done && lat < 100) begin
            if (bus.Busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat, bn;
        resetn = 1'b0;
        bus.Start = 1'b1; bus.ALUControl = 4'd2; bus.SrcA = 32'd1; bus.SrcB = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.Busy, bus.Done, observed()} !== 69'd0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, {bus.Busy, bus.Done, observed()});
            end
        end
        @(negedge clk); resetn = 1'b1; bus.Start = 1'b0;
        issue(4'd2, 32'd2, 32'd3, lat, bn);
        checks++;
        if ({lat, observed()} !== {32'd1, 32'd5, 32'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_first_add: got lat=%0d %h expected lat=1 result 5", lat, observed());
        end
    endtask

    task automatic run_table(input string name, input logic [3:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [66:0] exps[]);
        int lat, bn;
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i], as[i], bs[i], lat, bn);
            checks++;
            if (observed() !== exps[i] || lat !== 1) begin
                failures++;
                $display("FAIL %s[%0d]: got %h lat=%0d expected %h lat=1", name, i, observed(), lat, exps[i]);
            end
        end
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops[] = '{4'd2, 4'd3, 4'd3, 4'd2};
        logic [31:0] as[]  = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs[]  = '{32'd1, 32'd5, 32'd1, 32'd1};
        logic [66:0] ex[]  = '{{32'h80000000, 32'd0, 3'b010}, {32'd0, 32'd0, 3'b100},
                               {32'h7FFFFFFF, 32'd0, 3'b010}, {32'd0, 32'd0, 3'b100}};
        run_table("add_sub", ops, as, bs, ex);
    endtask

    task automatic test_compare_shift();
        logic [3:0]  ops[] = '{4'd6, 4'd7, 4'd10, 4'd8, 4'd9};
        logic [31:0] as[]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'hA5A5A5A5};
        logic [31:0] bs[]  = '{32'd1, 32'd1, 32'd4, 32'h21, 32'h40};
        logic [66:0] ex[]  = '{{32'd1, 32'd0, 3'b000}, {32'd0, 32'd0, 3'b100},
                               {32'hF8000000, 32'd0, 3'b000}, {32'h2468ACF0, 32'd0, 3'b000},
                               {32'hA5A5A5A5, 32'd0, 3'b000}};
        run_table("cmp_shift", ops, as, bs, ex);
    endtask

    task automatic test_illegal();
`ifdef ALU_MULT_EN
        logic [3:0]  ops[] = '{4'd13, 4'd15};
`else
        logic [3:0]  ops[] = '{4'd13, 4'd11};
`endif
        logic [31:0] as[]  = '{32'h1234, 32'hFFFFFFFF};
        logic [31:0] bs[]  = '{32'h5678, 32'hFFFFFFFF};
        logic [66:0] ex[]  = '{{32'd0, 32'd0, 3'b101}, {32'd0, 32'd0, 3'b101}};
        run_table("illegal", ops, as, bs, ex);
    endtask

    task automatic test_done_pulse();
        int lat, bn;
        issue(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, lat, bn);
        @(posedge clk); #1;
        checks++;
        if ({bus.Done, bus.ALUResult} !== {1'b0, 32'hFF00FF00}) begin
            failures++;
            $display("FAIL done_pulse: got done=%b res=%h expected done=0 res=ff00ff00", bus.Done, bus.ALUResult);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic [31:0] a, b;
        logic [66:0] exp;
        int lat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 10)); a = $urandom; b = $urandom;
            bus.Start = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
            model(op, a, b, exp, lat);
            @(posedge clk); #1;
            checks++;
            if (bus.Done !== 1'b1 || observed() !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d] op=%0d: got done=%b %h expected done=1 %h", i, op, bus.Done, observed(), exp);
            end
        end
        @(negedge clk); bus.Start = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [31:0] a, b;
        logic [31:0] specials[4] = '{32'd0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [66:0] exp;
        int elat, lat, bn;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            model(op, a, b, exp, elat);
            issue(op, a, b, lat, bn);
            checks++;
            if (observed() !== exp || lat !== elat) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d expected %h lat=%0d", i, op, a, b, observed(), lat, exp, elat);
            end
        end
    endtask

`ifdef ALU_MULT_EN
    task automatic test_mult();
        int lat, busy_n;
        @(negedge clk);
        bus.Start = 1'b1; bus.ALUControl = 4'd11; bus.SrcA = 32'hFFFFFFFF; bus.SrcB = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.SrcA = 32'd7; bus.SrcB = 32'd9;
        lat = 1; busy_n = 0;
        while (!bus.Done && lat < 100) begin
            if (bus.Busy) busy_n++;
            if (lat == 5) begin
                @(negedge clk);
                bus.Start = 1'b1; bus.ALUControl = 4'd2; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
                @(posedge clk); #1;
                bus.Start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            lat++;
        end
        checks++;
        if ({observed(), bus.Busy} !== {32'h00000001, 32'hFFFFFFFE, 3'b000, 1'b0} || lat !== 33 || busy_n !== 32) begin
            failures++;
            $display("FAIL multu_max: got %h busy=%b lat=%0d busy_cycles=%0d expected lo=1 hi=fffffffe lat=33 busy_cycles=32", observed(), bus.Busy, lat, busy_n);
        end
        @(negedge clk);
        bus.Start = 1'b1; bus.ALUControl = 4'd2; bus.SrcA = 32'd4; bus.SrcB = 32'd5;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        checks++;
        if ({bus.Done, bus.Busy, observed()} !== {2'b10, 32'd9, 32'd0, 3'b000}) begin
            failures++;
            $display("FAIL multu_done_cycle_accept: got done=%b busy=%b %h expected done=1 busy=0 result 9", bus.Done, bus.Busy, observed());
        end
    endtask

    task automatic test_reset_mid_mult();
        int lat, bn;
        @(negedge clk);
        bus.Start = 1'b1; bus.ALUControl = 4'd11; bus.SrcA = $urandom; bus.SrcB = $urandom;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.Busy, bus.Done, observed()} !== 69'd0) begin
            failures++;
            $display("FAIL reset_mid_mult: got %h expected 0", {bus.Busy, bus.Done, observed()});
        end
        @(negedge clk); resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_mult_no_done: got busy=%b done=%b expected 0 0", bus.Busy, bus.Done);
        end
        issue(4'd2, 32'd2, 32'd3, lat, bn);
        checks++;
        if ({lat, observed()} !== {32'd1, 32'd5, 32'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid_mult_add: got lat=%0d %h expected lat=1 result 5", lat, observed());
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start = 1'b0; bus.ALUControl = 4'd0; bus.SrcA = '0; bus.SrcB = '0;
        resetn = 1'b0;
        test_reset();
        test_add_sub();
        test_compare_shift();
        test_illegal();
        test_done_pulse();
        test_back_to_back();
`ifdef ALU_MULT_EN
        test_mult();
        test_reset_mid_mult();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
